// File: rtl/local_pattern_history_table.sv
// Second-level local predictor table: 2-bit saturating counters indexed by {pc slot, local history}.
// Optional same-cycle forwarding of a training write to the lookup port: define PHT_BYPASS_EN.
module local_pattern_history_table #(
  parameter int         PC_BITS   = 4,
  parameter int         HIST_BITS = 4,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 update_pattern,
  input  logic                 wb_take_jump,
  input  logic [15:0]          lookup_pc,
  input  logic [15:0]          resolved_pc,
  input  logic [HIST_BITS-1:0] history,
  output logic                 predict_taken
);

  localparam int IDX_BITS = PC_BITS + HIST_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;
  localparam int SLOTS    = 1 << PC_BITS;

  logic [1:0]           ctr  [DEPTH];
  logic [HIST_BITS-1:0] snap [SLOTS];

  logic [PC_BITS-1:0]  lookup_slot;
  logic [PC_BITS-1:0]  resolved_slot;
  logic [IDX_BITS-1:0] li;
  logic [IDX_BITS-1:0] ui;
  logic [1:0]          ctr_cur;
  logic [1:0]          ctr_next;
  logic                pred_raw;

  // Word-aligned slot; bit 0 and upper pc bits alias by design.
  assign lookup_slot   = lookup_pc[PC_BITS:1];
  assign resolved_slot = resolved_pc[PC_BITS:1];
  assign li            = {lookup_slot, history};
  assign ui            = {resolved_slot, snap[resolved_slot]};
  assign ctr_cur       = ctr[ui];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[15:PC_BITS+1], lookup_pc[0],
                            resolved_pc[15:PC_BITS+1], resolved_pc[0]};

  always_comb begin
    ctr_next = ctr_cur;
    if (wb_take_jump) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

`ifdef PHT_BYPASS_EN
  assign pred_raw = (update_pattern && (li == ui)) ? ctr_next[1] : ctr[li][1];
`else
  assign pred_raw = ctr[li][1];
`endif

  // Gate during reset so a forwarded write cannot leak through while tables are held.
  assign predict_taken = rst ? CTR_INIT[1] : pred_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= CTR_INIT;
      for (int j = 0; j < SLOTS; j++) snap[j] <= '0;
    end else begin
      snap[lookup_slot] <= history;
      if (update_pattern) ctr[ui] <= ctr_next;
    end
  end

endmodule

// File: tb/tb_local_pattern_history_table.sv
// Scoreboard bench for local_pattern_history_table: driver queues expected predictions,
// negedge monitor pops and compares.
module tb_local_pattern_history_table;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        update_pattern = 1'b0;
  logic        wb_take_jump = 1'b0;
  logic [15:0] lookup_pc = '0;
  logic [15:0] resolved_pc = '0;
  logic [3:0]  history = '0;
  logic        predict_taken;

  logic  mon_en = 1'b0;
  logic  exp_q [$];
  string name_q [$];
  int    checks = 0;
  int    errors = 0;

`ifdef PHT_BYPASS_EN
  localparam logic BYP_EXP = 1'b1;
`else
  localparam logic BYP_EXP = 1'b0;
`endif

  local_pattern_history_table #(.PC_BITS(4), .HIST_BITS(4), .CTR_INIT(2'b01)) dut (
    .clk            (clk),
    .rst            (rst),
    .update_pattern (update_pattern),
    .wb_take_jump   (wb_take_jump),
    .lookup_pc      (lookup_pc),
    .resolved_pc    (resolved_pc),
    .history        (history),
    .predict_taken  (predict_taken)
  );

  always #5 clk = ~clk;

  // Monitor: the prediction is combinational, so it is sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL monitor got %0b with no expected entry queued", predict_taken);
      end else begin
        logic  e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (predict_taken !== e) begin
          errors++;
          $display("FAIL %s got %0b expected %0b", n, predict_taken, e);
        end
      end
    end
  end

  task automatic push_exp(input logic e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input logic u, input logic tj, input logic [15:0] lpc,
                      input logic [15:0] rpc, input logic [3:0] h,
                      input logic chk, input logic e, input string nm);
    @(posedge clk);
    #1;
    update_pattern = u;
    wb_take_jump   = tj;
    lookup_pc      = lpc;
    resolved_pc    = rpc;
    history        = h;
    if (chk) push_exp(e, nm);
    mon_en = chk;
  endtask

  task automatic chk(input logic [15:0] lpc, input logic [3:0] h, input logic e,
                     input string nm);
    step(1'b0, 1'b0, lpc, 16'h0000, h, 1'b1, e, nm);
  endtask

  // Trains the entry selected by rpc while looking up slot 0, keeping li != ui.
  task automatic train(input logic tj, input logic [15:0] rpc, input string nm);
    step(1'b1, tj, 16'h0000, rpc, 4'h0, 1'b1, 1'b0, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:11] dirs;
    logic [0:11] exps;

    // Reset state
    step(1'b0, 1'b0, 16'h0004, 16'h0000, 4'h0, 1'b1, 1'b0, "rst_pred");
    step(1'b1, 1'b1, 16'h0004, 16'h0004, 4'h0, 1'b1, 1'b0, "rst_pred_upd");
    @(posedge clk);
    #1;
    rst = 1'b0;
    update_pattern = 1'b0;
    mon_en = 1'b0;
    for (int s = 0; s < 16; s++)
      chk(16'(s << 1), 4'(s), 1'b0, $sformatf("init_slot%0d", s));

    // Single taken update on {slot2, h0}
    chk(16'h0004, 4'h0, 1'b0, "pre_train");
    train(1'b1, 16'h0004, "train_other");
    chk(16'h0004, 4'h0, 1'b1, "after_taken");
    chk(16'h0004, 4'h1, 1'b0, "indep_hist");
    chk(16'h0004, 4'h0, 1'b1, "snap_restore");

    // Saturation: 5 taken, 5 not-taken, 2 taken from counter 2
    dirs = 12'b1111_1000_0011;
    exps = 12'b1111_1100_0001;
    for (int k = 0; k < 12; k++) begin
      train(dirs[k], 16'h0004, "sat_other");
      chk(16'h0004, 4'h0, exps[k], $sformatf("sat_step%0d", k));
    end

    // Aliasing: 0x0024 shares slot 2, 0x0006 is slot 3
    chk(16'h0024, 4'h0, 1'b1, "alias_read");
    chk(16'h0006, 4'h0, 1'b0, "slot3_clean");
    train(1'b0, 16'h0024, "alias_upd_other");
    chk(16'h0004, 4'h0, 1'b0, "alias_train");
    chk(16'h0006, 4'h0, 1'b0, "slot3_still");

    // Same-cycle lookup and update of the same entry (counter 01 -> 10)
    step(1'b1, 1'b1, 16'h0004, 16'h0004, 4'h0, 1'b1, BYP_EXP, "bypass_same");
    chk(16'h0004, 4'h0, 1'b1, "bypass_next");

    // Reset asserted mid-cycle during an update (counter is 10 here)
    @(posedge clk);
    #1;
    update_pattern = 1'b1;
    wb_take_jump   = 1'b1;
    lookup_pc      = 16'h0004;
    resolved_pc    = 16'h0004;
    history        = 4'h0;
    #2;
    rst = 1'b1;
    push_exp(1'b0, "rst_mid");
    mon_en = 1'b1;
    step(1'b1, 1'b1, 16'h0004, 16'h0004, 4'h0, 1'b1, 1'b0, "rst_hold");
    @(posedge clk);
    #1;
    rst = 1'b0;
    update_pattern = 1'b0;
    push_exp(1'b0, "post_rst");
    train(1'b1, 16'h0004, "post_rst_other");
    chk(16'h0004, 4'h0, 1'b1, "post_rst_train");

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    update_pattern = 1'b0;
    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
